// File: rtl/pipe_wb_regfile.sv
// ---------------------------------------------------------------------------
// pipe_wb_regfile
//   Writeback stage and architectural register file of the 5-stage pipeline.
//   Takes the MEM/WB pipeline register outputs, picks the writeback data
//   (load data or ALU result) and commits it to a 2-read / 1-write register
//   file that feeds the ID stage. A committed-writeback counter is kept for
//   debug and performance monitoring.
//
//   Optional feature (compile-time macro): REGFILE_BYPASS_EN
//     defined   : a write in flight is forwarded to a read port that
//                 addresses the same (nonzero) register in the same cycle.
//     undefined : read ports return the stored value until the write commits.
//
// Parameters
//   DW     data width of registers and writeback data
//   AW     register address width (depth 2**AW, r0 hardwired to zero)
//   CNT_W  width of the committed-writeback counter
//
// Ports
//   clk       in   pipeline clock, rising edge
//   clrn      in   asynchronous reset, active-high
//   wwreg     in   writeback enable from MEM/WB
//   wm2reg    in   1: write memory data, 0: write ALU result
//   wmo       in   memory load data from MEM/WB
//   walu      in   ALU result from MEM/WB
//   wrn       in   destination register number from MEM/WB
//   rna       in   read port A address (ID stage rs)
//   rnb       in   read port B address (ID stage rt)
//   qa        out  read port A data
//   qb        out  read port B data
//   wdi       out  selected writeback data (to forwarding muxes)
//   wb_count  out  number of committed register writes (wraps silently)
//
// There is no handshake on this block: a write is offered by wwreg for one
// cycle and is always accepted at the next rising edge (unless reset is high).
// ---------------------------------------------------------------------------
module pipe_wb_regfile #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             wwreg,
  input  logic             wm2reg,
  input  logic [DW-1:0]    wmo,
  input  logic [DW-1:0]    walu,
  input  logic [AW-1:0]    wrn,
  input  logic [AW-1:0]    rna,
  input  logic [AW-1:0]    rnb,
  output logic [DW-1:0]    qa,
  output logic [DW-1:0]    qb,
  output logic [DW-1:0]    wdi,
  output logic [CNT_W-1:0] wb_count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] regs [DEPTH];
  logic          we;

  // Writeback data select is purely combinational so the forwarding muxes
  // see it in the same cycle.
  assign wdi = wm2reg ? wmo : walu;

  // Writes to r0 are dropped here, which also keeps them out of the counter.
  assign we = wwreg && (wrn != '0);

  // Register array and counter. Reset clears every entry; r0 is never
  // written afterwards, and the read mux forces it to zero regardless.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wb_count <= '0;
    end else if (we) begin
      regs[wrn] <= wdi;
      wb_count  <= wb_count + CNT_W'(1);
    end
  end

  // Combinational read ports.
  always_comb begin
    qa = '0;
    if (rna != '0) begin
      qa = regs[rna];
    end
`ifdef REGFILE_BYPASS_EN
    // we already guarantees wrn is nonzero, so r0 can never be bypassed.
    if (we && (wrn == rna)) begin
      qa = wdi;
    end
`endif
  end

  always_comb begin
    qb = '0;
    if (rnb != '0) begin
      qb = regs[rnb];
    end
`ifdef REGFILE_BYPASS_EN
    if (we && (wrn == rnb)) begin
      qb = wdi;
    end
`endif
  end

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_pipe_wb_regfile
//   Directed bench for pipe_wb_regfile. The counter is built 4 bits wide so
//   that wrap-around can be reached in a few cycles.
// ---------------------------------------------------------------------------
module tb_pipe_wb_regfile;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             clrn;
  logic             wwreg;
  logic             wm2reg;
  logic [DW-1:0]    wmo;
  logic [DW-1:0]    walu;
  logic [AW-1:0]    wrn;
  logic [AW-1:0]    rna;
  logic [AW-1:0]    rnb;
  logic [DW-1:0]    qa;
  logic [DW-1:0]    qb;
  logic [DW-1:0]    wdi;
  logic [CNT_W-1:0] wb_count;

  always #5 clk = ~clk;

  pipe_wb_regfile #(
    .DW    (DW),
    .AW    (AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wmo      (wmo),
    .walu     (walu),
    .wrn      (wrn),
    .rna      (rna),
    .rnb      (rnb),
    .qa       (qa),
    .qb       (qb),
    .wdi      (wdi),
    .wb_count (wb_count)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs are changed and
  // outputs sampled only at these off-edge points.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we_i, input logic m2r, input logic [31:0] mo,
                       input logic [31:0] alu, input logic [4:0] rn);
    wwreg  = we_i;
    wm2reg = m2r;
    wmo    = mo;
    walu   = alu;
    wrn    = rn;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we_i;
    logic        m2r;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] e_wdi;
    logic [31:0] e_qa;
    logic [31:0] e_qb;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] exp_qa_pre;

    // Each vector: present the write, check wdi before the edge, clock it,
    // drop wwreg, then read back through both ports.
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 5'd5,  5'd5,  5'd0,
                32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 4'd1};
    vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 5'd6,  5'd5,  5'd6,
                32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 4'd2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  5'd0,  5'd6,
                32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF, 4'd2};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_AAAA, 32'h0000_BBBB, 5'd5,  5'd5,  5'd5,
                32'h0000_AAAA, 32'h1234_5678, 32'h1234_5678, 4'd2};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0011, 5'd7,  5'd7,  5'd7,
                32'h0000_0011, 32'h0000_0011, 32'h0000_0011, 4'd3};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0031, 32'hCAFE_0000, 5'd31, 5'd31, 5'd5,
                32'h0000_0031, 32'h0000_0031, 32'h1234_5678, 4'd4};

    // ---------- reset ----------
    clrn = 1'b1;
    idle();
    rna = '0;
    rnb = '0;
    tick();
    tick();
    for (int a = 0; a < 32; a++) begin
      rna = 5'(a);
      rnb = 5'(31 - a);
      #1;
      chk($sformatf("rst_qa[%0d]", a), qa, 32'h0);
      chk($sformatf("rst_qb[%0d]", 31 - a), qb, 32'h0);
    end
    chk("rst_cnt", 32'(wb_count), 32'h0);
    clrn = 1'b0;
    tick();

    // ---------- table-driven vectors ----------
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].we_i, vecs[i].m2r, vecs[i].mo, vecs[i].alu, vecs[i].rn);
      rna = vecs[i].ra;
      rnb = vecs[i].rb;
      #1;
      chk($sformatf("v%0d_wdi", i), wdi, vecs[i].e_wdi);
      tick();
      wwreg = 1'b0;
      #1;
      chk($sformatf("v%0d_qa", i), qa, vecs[i].e_qa);
      chk($sformatf("v%0d_qb", i), qb, vecs[i].e_qb);
      chk($sformatf("v%0d_cnt", i), 32'(wb_count), 32'(vecs[i].e_cnt));
    end

    // ---------- X data with writeback disabled ----------
    drive(1'b0, 1'b0, 'x, 'x, 5'd5);
    rna = 5'd5;
    rnb = 5'd7;
    tick();
    tick();
    chk("x_qa5", qa, 32'h1234_5678);
    chk("x_qb7", qb, 32'h0000_0011);
    chk("x_cnt", 32'(wb_count), 32'd4);

    // ---------- read during write, reg 7 holds 0x11 ----------
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd7);
    rna = 5'd7;
    rnb = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_qa_pre = 32'h0000_0022;
`else
    exp_qa_pre = 32'h0000_0011;
`endif
    #1;
    chk("rdw_qa_pre", qa, exp_qa_pre);
    chk("rdw_qb_pre", qb, exp_qa_pre);
    tick();
    idle();
    #1;
    chk("rdw_qa_post", qa, 32'h0000_0022);
    chk("rdw_cnt", 32'(wb_count), 32'd5);

    // ---------- reset mid-stream ----------
    drive(1'b1, 1'b0, 32'h0, 32'h0000_00A5, 5'd3);
    rna = 5'd3;
    tick();
    idle();
    #1;
    chk("mid_qa3_before", qa, 32'h0000_00A5);
    chk("mid_cnt_before", 32'(wb_count), 32'd6);
    drive(1'b1, 1'b1, 32'h0000_0077, 32'h0, 5'd3);
    #1;
    clrn = 1'b1;   // asserted between edges, write still pending
    #1;
    chk("mid_qa3_rst", qa, 32'h0);
    chk("mid_cnt_rst", 32'(wb_count), 32'h0);
    chk("mid_wdi_rst", wdi, 32'h0000_0077);
    tick();        // edge while reset is high: the pending write is lost
    chk("mid_qa3_edge", qa, 32'h0);
    chk("mid_cnt_edge", 32'(wb_count), 32'h0);
    idle();
    @(negedge clk);
    clrn = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0009, 5'd3);
    tick();        // first edge after release accepts the write
    idle();
    #1;
    chk("post_rst_qa3", qa, 32'h0000_0009);
    chk("post_rst_cnt", 32'(wb_count), 32'd1);

    // ---------- counter wrap ----------
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'(i), 5'((i % 31) + 1));
      tick();
      if (i == 14) begin
        chk("wrap_cnt15", 32'(wb_count), 32'd15);
      end
      if (i == 15) begin
        chk("wrap_cnt0", 32'(wb_count), 32'd0);
      end
    end
    chk("wrap_cnt17", 32'(wb_count), 32'd1);
    idle();
    tick();
    tick();
    tick();
    chk("wrap_hold", 32'(wb_count), 32'd1);
    rna = 5'd17;
    #1;
    chk("wrap_qa17", qa, 32'd16);

    // ---------- report ----------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
